// File: rtl/scroll_pkg.sv
// Shared types and defaults for the scroll tick generator.
// State encoding, parameter defaults and counter width helper.
package scroll_pkg;

  typedef enum logic {
    ST_AUTO   = 1'b0,
    ST_PAUSED = 1'b1
  } state_e;

  localparam int unsigned TICK_PERIOD_DEF     = 25_000_000;
  localparam int unsigned DEBOUNCE_CYCLES_DEF = 500_000;

  function automatic int unsigned cnt_w(input int unsigned n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/button_conditioner.sv
// Raw pushbutton -> 2-flop sync -> debounce -> one-cycle press pulse.
// Releases are debounced too but never produce a pulse.
module button_conditioner
  import scroll_pkg::*;
#(
  parameter int unsigned DEBOUNCE_CYCLES = DEBOUNCE_CYCLES_DEF
) (
  input  logic clk,
  input  logic reset,
  input  logic btn_i,
  output logic press_o
);

  localparam int unsigned CW = cnt_w(DEBOUNCE_CYCLES);
  localparam logic [CW-1:0] CNT_MAX = CW'(DEBOUNCE_CYCLES - 1);

  logic          sync1_q;
  logic          sync2_q;
  logic          db_q;
  logic          db_d;
  logic          db_prev_q;
  logic [CW-1:0] cnt_q;
  logic [CW-1:0] cnt_d;

  // Counter only runs while the synced level disagrees with db.
  always_comb begin
    cnt_d = cnt_q;
    db_d  = db_q;
    if (sync2_q == db_q) begin
      cnt_d = '0;
    end else if (cnt_q == CNT_MAX) begin
      db_d  = sync2_q;
      cnt_d = '0;
    end else begin
      cnt_d = cnt_q + 1'b1;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      sync1_q   <= 1'b0;
      sync2_q   <= 1'b0;
      db_q      <= 1'b0;
      db_prev_q <= 1'b0;
      cnt_q     <= '0;
    end else begin
      sync1_q   <= btn_i;
      sync2_q   <= sync1_q;
      db_q      <= db_d;
      db_prev_q <= db_q;
      cnt_q     <= cnt_d;
    end
  end

  assign press_o = db_q & ~db_prev_q;

endmodule

// File: rtl/scroll_tick_gen.sv
// Advance strobe generator: periodic in AUTO, per step press in PAUSED.
// Mode button toggles AUTO/PAUSED and outranks step press and tick wrap.
module scroll_tick_gen
  import scroll_pkg::*;
#(
  parameter int unsigned TICK_PERIOD     = TICK_PERIOD_DEF,
  parameter int unsigned DEBOUNCE_CYCLES = DEBOUNCE_CYCLES_DEF
) (
  input  logic clk,
  input  logic reset,
  input  logic btn_mode,
  input  logic btn_step,
  output logic advance,
  output logic paused
);

  localparam int unsigned TW = cnt_w(TICK_PERIOD);
  localparam logic [TW-1:0] TICK_MAX = TW'(TICK_PERIOD - 1);

  state_e        state_q;
  logic [TW-1:0] tick_q;
  logic          advance_q;
  logic          mode_press;
  logic          step_press;
  logic          tick_wrap;

  button_conditioner #(
    .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)
  ) u_mode (
    .clk    (clk),
    .reset  (reset),
    .btn_i  (btn_mode),
    .press_o(mode_press)
  );

  button_conditioner #(
    .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)
  ) u_step (
    .clk    (clk),
    .reset  (reset),
    .btn_i  (btn_step),
    .press_o(step_press)
  );

  assign tick_wrap = (tick_q == TICK_MAX);

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q   <= ST_AUTO;
      tick_q    <= '0;
      advance_q <= 1'b0;
    end else begin
      advance_q <= 1'b0;
      unique case (state_q)
        ST_AUTO: begin
          if (mode_press) begin
            state_q <= ST_PAUSED;
            tick_q  <= '0;
          end else if (tick_wrap) begin
            tick_q    <= '0;
            advance_q <= 1'b1;
          end else begin
            tick_q <= tick_q + 1'b1;
          end
        end
        ST_PAUSED: begin
          tick_q <= '0;
          if (mode_press) begin
            state_q <= ST_AUTO;
          end else if (step_press) begin
            advance_q <= 1'b1;
          end
        end
      endcase
    end
  end

  assign advance = advance_q;
  assign paused  = (state_q == ST_PAUSED);

endmodule

// File: tb/tb_scroll_tick_gen.sv
// Randomized and directed bench for scroll_tick_gen against a
// history-based reference model of debounce, mode and tick timing.
module tb_scroll_tick_gen;

  localparam int TP = 8;
  localparam int DB = 4;

  logic clk = 1'b0;
  logic reset = 1'b1;
  logic btn_mode = 1'b0;
  logic btn_step = 1'b0;
  logic advance;
  logic paused;

  int checks = 0;
  int fails  = 0;

  bit hm[$];
  bit hs[$];
  bit db_m, db_s, pm, ps;
  bit ex_adv, ex_pau;
  int ecount = 0;
  int base = 0;

  always #5 clk = ~clk;

  scroll_tick_gen #(
    .TICK_PERIOD    (TP),
    .DEBOUNCE_CYCLES(DB)
  ) dut (
    .clk     (clk),
    .reset   (reset),
    .btn_mode(btn_mode),
    .btn_step(btn_step),
    .advance (advance),
    .paused  (paused)
  );

  // A level is accepted once the last DB synchronized samples
  // (raw samples two edges old and older) all differ from it.
  function automatic bit differs(input bit q[$], input bit db);
    int idx;
    bit v;
    for (int j = 1; j <= DB; j++) begin
      idx = q.size() - 1 - j;
      v = (idx >= 0) ? q[idx] : 1'b0;
      if (v == db) return 1'b0;
    end
    return 1'b1;
  endfunction

  task automatic model_reset();
    hm.delete();
    hs.delete();
    db_m = 0; db_s = 0; pm = 0; ps = 0;
    ex_adv = 0; ex_pau = 0;
    base = ecount;
  endtask

  task automatic cycle();
    bit mp, sp, fm, fs;
    @(posedge clk);
    if (reset) begin
      model_reset();
    end else begin
      ecount++;
      mp = pm;
      sp = ps;
      ex_adv = 0;
      if (mp) begin
        ex_pau = !ex_pau;
        base = ecount;
      end else if (ex_pau) begin
        ex_adv = sp;
      end else begin
        ex_adv = ((ecount - base) % TP == 0);
      end
      fm = differs(hm, db_m);
      fs = differs(hs, db_s);
      pm = fm && !db_m;
      ps = fs && !db_s;
      if (fm) db_m = !db_m;
      if (fs) db_s = !db_s;
      hm.push_back(btn_mode);
      hs.push_back(btn_step);
      if (hm.size() > DB + 2) void'(hm.pop_front());
      if (hs.size() > DB + 2) void'(hs.pop_front());
    end
    #1;
  endtask

  task automatic test_reset();
    reset = 1; btn_mode = 0; btn_step = 0;
    model_reset();
    for (int i = 0; i < 3; i++) begin
      cycle();
      checks++;
      if ({advance, paused} !== 2'b00) begin
        fails++;
        $display("FAIL reset_hold cyc=%0d adv=%b pau=%b want 0 0",
                 i, advance, paused);
      end
    end
    reset = 0;
    for (int i = 1; i <= 26; i++) begin
      cycle();
      checks++;
      if ({advance, paused} !== {ex_adv, ex_pau}) begin
        fails++;
        $display("FAIL reset_model edge=%0d got=%b%b want=%b%b",
                 i, advance, paused, ex_adv, ex_pau);
      end
      checks++;
      if (advance !== (i % TP == 0) || paused !== 1'b0) begin
        fails++;
        $display("FAIL auto_period edge=%0d adv=%b pau=%b want %0d 0",
                 i, advance, paused, (i % TP == 0));
      end
    end
  endtask

  task automatic test_mode_bounce();
    for (int i = 0; i < 12; i++) begin
      btn_mode = ((i / 2) % 2 == 0);
      cycle();
      checks++;
      if ({advance, paused} !== {ex_adv, ex_pau}) begin
        fails++;
        $display("FAIL bounce_model i=%0d got=%b%b want=%b%b",
                 i, advance, paused, ex_adv, ex_pau);
      end
    end
    btn_mode = 1;
    for (int j = 1; j <= 20; j++) begin
      cycle();
      checks++;
      if (paused !== (j >= 7) || (j >= 7 && advance)) begin
        fails++;
        $display("FAIL mode_hold j=%0d pau=%b adv=%b want pau=%0d",
                 j, paused, advance, (j >= 7));
      end
    end
    btn_mode = 0;
    for (int j = 1; j <= 10; j++) begin
      cycle();
      checks++;
      if ({advance, paused} !== {ex_adv, ex_pau}) begin
        fails++;
        $display("FAIL mode_release j=%0d got=%b%b want=%b%b",
                 j, advance, paused, ex_adv, ex_pau);
      end
    end
  endtask

  task automatic test_step();
    int n = 0;
    for (int ph = 0; ph < 4; ph++) begin
      btn_step = (ph % 2 == 0);
      for (int j = 1; j <= ((ph == 0) ? 30 : 10); j++) begin
        cycle();
        if (advance) n++;
        checks++;
        if (advance !== (btn_step && j == 7) || paused !== 1'b1) begin
          fails++;
          $display("FAIL step ph=%0d j=%0d adv=%b pau=%b",
                   ph, j, advance, paused);
        end
      end
    end
    checks++;
    if (n != 2) begin
      fails++;
      $display("FAIL step_count got=%0d want=2", n);
    end
  endtask

  task automatic test_mode_return();
    for (int j = 1; j <= 20; j++) begin
      btn_mode = (j <= 10);
      cycle();
      checks++;
      if (paused !== (j < 7) || advance !== (j == 15)) begin
        fails++;
        $display("FAIL mode_return j=%0d pau=%b adv=%b want %0d %0d",
                 j, paused, advance, (j < 7), (j == 15));
      end
    end
  endtask

  task automatic test_both();
    for (int j = 1; j <= 16; j++) begin
      btn_mode = (j <= 8);
      cycle();
      checks++;
      if ({advance, paused} !== {ex_adv, ex_pau}) begin
        fails++;
        $display("FAIL both_setup j=%0d got=%b%b want=%b%b",
                 j, advance, paused, ex_adv, ex_pau);
      end
    end
    btn_mode = 1; btn_step = 1;
    for (int j = 1; j <= 10; j++) begin
      cycle();
      checks++;
      if (paused !== (j < 7) || advance !== 1'b0) begin
        fails++;
        $display("FAIL both_press j=%0d pau=%b adv=%b want %0d 0",
                 j, paused, advance, (j < 7));
      end
    end
    btn_mode = 0; btn_step = 0;
    for (int j = 1; j <= 10; j++) begin
      cycle();
      checks++;
      if ({advance, paused} !== {ex_adv, ex_pau}) begin
        fails++;
        $display("FAIL both_after j=%0d got=%b%b want=%b%b",
                 j, advance, paused, ex_adv, ex_pau);
      end
    end
  endtask

  task automatic test_reset_mid();
    reset = 1;
    model_reset();
    cycle(); cycle();
    reset = 0;
    for (int j = 1; j <= 5; j++) cycle();
    reset = 1;
    model_reset();
    #1;
    for (int j = 0; j < 4; j++) begin
      checks++;
      if ({advance, paused} !== 2'b00) begin
        fails++;
        $display("FAIL reset_mid j=%0d adv=%b pau=%b want 0 0",
                 j, advance, paused);
      end
      if (j < 3) cycle();
    end
    reset = 0;
    for (int j = 1; j <= 10; j++) begin
      cycle();
      checks++;
      if (advance !== (j == 8) || paused !== 1'b0) begin
        fails++;
        $display("FAIL reset_restart j=%0d adv=%b pau=%b want %0d 0",
                 j, advance, paused, (j == 8));
      end
    end
  endtask

  task automatic test_random();
    int cm = 0;
    int cs = 0;
    int rc = 0;
    for (int i = 0; i < 3000; i++) begin
      if (rc > 0) begin
        rc--;
        if (rc == 0) reset = 0;
      end else if ($urandom_range(0, 399) == 0) begin
        reset = 1;
        model_reset();
        rc = $urandom_range(1, 3);
      end
      if (cm == 0) begin
        btn_mode = 1'($urandom_range(0, 1));
        cm = $urandom_range(1, 16);
      end else cm--;
      if (cs == 0) begin
        btn_step = 1'($urandom_range(0, 1));
        cs = $urandom_range(1, 9);
      end else cs--;
      cycle();
      checks++;
      if ({advance, paused} !== {ex_adv, ex_pau}) begin
        fails++;
        $display("FAIL random i=%0d got=%b%b want=%b%b",
                 i, advance, paused, ex_adv, ex_pau);
      end
    end
    reset = 0; btn_mode = 0; btn_step = 0;
  endtask

  initial begin
    test_reset();
    test_mode_bounce();
    test_step();
    test_mode_return();
    test_both();
    test_reset_mid();
    test_random();
    $display("End of test - %0d assertions evaluated, %0d failures",
             checks, fails);
    $finish;
  end

endmodule

// File: doc/scroll_tick_gen.md
# scroll_tick_gen

Timing and control stage directly upstream of the message address counter. Generates the one-cycle `advance` strobe that steps the active character address: periodically in auto-scroll mode, or once per debounced push of a step button in paused mode. A second pushbutton toggles between the two modes. Raw board buttons enter here; nothing downstream sees an unconditioned button.

## Interface
- `TICK_PERIOD`, default 25_000_000: clock cycles between auto-mode strobes; legal range ≥ 2.
- `DEBOUNCE_CYCLES`, default 500_000: consecutive stable synchronized samples required to accept a button level change; legal range ≥ 1.
- `clk`  in  1  single system clock; all logic on its rising edge.
- `reset`  in  1  asynchronous, active-high reset.
- `btn_mode`  in  1  raw asynchronous pushbutton, active-high; each accepted press toggles AUTO/PAUSED.
- `btn_step`  in  1  raw asynchronous pushbutton, active-high; each accepted press in PAUSED emits one strobe.
- `advance`  out  1  registered one-cycle strobe; drives the address counter's step input.
- `paused`  out  1  registered status, 1 in PAUSED; drives an LED.

## Operation
- Reset values: `advance`=0, `paused`=0, state AUTO, tick counter 0, all synchronizer/debounce registers 0, debounced levels 0.
- Button conditioning, per button: 2-flop synchronizer → `s`. Debounce counter clears whenever `s` equals debounced level `db`; otherwise increments. When it reaches `DEBOUNCE_CYCLES-1` while `s`≠`db`, `db` takes `s` and the counter clears. Press pulse = `db` & ~`db_prev`, exactly one cycle per accepted rising level. Releases produce no pulse.
- States: AUTO, PAUSED.
- AUTO: tick counter counts 0..`TICK_PERIOD-1` and wraps. `advance` is registered high for one cycle on the wrap. Step presses are ignored. A mode press moves to PAUSED and clears the tick counter.
- PAUSED: tick counter held at 0. A step press registers `advance` high for one cycle. A mode press moves to AUTO with the tick counter at 0.
- Priority within one cycle, highest first: reset, mode press, step press/tick wrap.
  - A mode press in the same cycle as an AUTO wrap suppresses that strobe.
  - A mode press together with a step press in PAUSED returns to AUTO with no strobe.
- Bounce shorter than `DEBOUNCE_CYCLES` samples yields no press. A button held across reset release is accepted as a fresh press after debounce.
- Counter widths are `$clog2` of the respective parameter, with a minimum width of 1.

## Timing
- Auto strobe period is exactly `TICK_PERIOD` cycles. After reset release, the first `advance` is high in the cycle following the `TICK_PERIOD`-th rising edge.
- Button latency: edge k is the first edge sampling raw high. `db` rises at edge k+1+`DEBOUNCE_CYCLES`; the press pulse is high in the following cycle; `advance` or the `paused` change registers at edge k+2+`DEBOUNCE_CYCLES`.
- `advance` is never high in two consecutive cycles. Minimum spacing is 2 cycles in PAUSED and `TICK_PERIOD` in AUTO.
- Reset mid-operation clears everything immediately. An in-flight strobe is dropped, and counting restarts from 0 on release.

## Structure
- Shared package `scroll_pkg`: state encoding (`ST_AUTO`=0, `ST_PAUSED`=1), default values for `TICK_PERIOD` and `DEBOUNCE_CYCLES`.
- Sub-module `button_conditioner` (synchronizer + debounce + press pulse, parameter `DEBOUNCE_CYCLES`), instantiated twice. Top holds the FSM and tick counter.

## Test plan
Bench parameters: `TICK_PERIOD`=8, `DEBOUNCE_CYCLES`=4.
- Reset release, buttons low → `advance` high for one cycle after edges 8, 16, 24; `paused`=0 throughout.
- `btn_mode` toggled every 2 cycles for 12 cycles, then held high 20 cycles → exactly one accepted press; `paused` rises 6 cycles after the hold begins; no strobes while paused.
- In PAUSED, `btn_step` held 30 cycles, released 10, pressed again → exactly two `advance` pulses, each 6 cycles after its press.
- From PAUSED, mode press → `paused`=0; the next `advance` arrives 8 cycles after `paused` falls.
- In PAUSED, both buttons rise on the same edge → `paused` goes 0; no `advance` in that cycle.
- `reset` asserted at tick count 5 and released 3 cycles later → `advance`=0 and `paused`=0 during reset; next strobe after 8 edges from release.
